// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU controller and its multiply/divide sequencer:
// funct fields, ALUOp classes, 4-bit ALU control words and sequencer states.
package alu_ctrl_pkg;

  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  localparam logic [2:0] ALUOP_MEM   = 3'b000;
  localparam logic [2:0] ALUOP_BEQ   = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE = 3'b010;
  localparam logic [2:0] ALUOP_SLTI  = 3'b011;
  localparam logic [2:0] ALUOP_ORI   = 3'b100;
  localparam logic [2:0] ALUOP_ANDI  = 3'b101;

  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_OR   = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_SUB  = 4'b0110;
  localparam logic [3:0] CTRL_SLT  = 4'b0111;
  localparam logic [3:0] CTRL_MFHI = 4'b1000;
  localparam logic [3:0] CTRL_MFLO = 4'b1001;
  localparam logic [3:0] CTRL_MD   = 4'b1010;
  localparam logic [3:0] CTRL_NOR  = 4'b1100;
  localparam logic [3:0] CTRL_ILL  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/alu_md_iter.sv
// One-bit-per-step shift-add multiplier / restoring divider on operand magnitudes.
// The divider half exists only when ALU_CTRL_DIV_EN is defined.
module alu_md_iter
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
`ifdef ALU_CTRL_DIV_EN
  input  logic             div_i,
`endif
  input  logic             start_i,
  input  logic             step_i,
  input  logic             last_i,
  input  logic             sgn_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] res_hi_o,
  output logic [WIDTH-1:0] res_lo_o
);

  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opnd_q, opnd_d;
  logic             neg_q, neg_d, rneg_q, rneg_d;
  logic [WIDTH-1:0] a_mag, b_mag, nxt_hi, nxt_lo;
  logic [WIDTH:0]   sum;
  logic [2*WIDTH-1:0] prod;
`ifdef ALU_CTRL_DIV_EN
  logic             div_q, div_d;
  logic [WIDTH:0]   shifted, trial;
`endif

  always_comb begin
    a_mag = (sgn_i && a_i[WIDTH-1]) ? -a_i : a_i;
    b_mag = (sgn_i && b_i[WIDTH-1]) ? -b_i : b_i;
    // Multiply: {carry, hi, lo} shifts right, lo holds the remaining multiplier bits.
    sum    = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    nxt_hi = sum[WIDTH:1];
    nxt_lo = {sum[0], acc_lo_q[WIDTH-1:1]};
`ifdef ALU_CTRL_DIV_EN
    shifted = {acc_hi_q, acc_lo_q[WIDTH-1]};
    trial   = shifted - {1'b0, opnd_q};
    if (div_q) begin
      if (!trial[WIDTH]) begin
        nxt_hi = trial[WIDTH-1:0];
        nxt_lo = {acc_lo_q[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi = shifted[WIDTH-1:0];
        nxt_lo = {acc_lo_q[WIDTH-2:0], 1'b0};
      end
    end
`endif
    prod     = {nxt_hi, nxt_lo};
    res_hi_o = nxt_hi;
    res_lo_o = nxt_lo;
    // Sign fix-up is applied only to the value produced by the final step.
    if (last_i) begin
`ifdef ALU_CTRL_DIV_EN
      if (div_q) begin
        res_lo_o = neg_q  ? -nxt_lo : nxt_lo;
        res_hi_o = rneg_q ? -nxt_hi : nxt_hi;
      end else if (neg_q) begin
        {res_hi_o, res_lo_o} = -prod;
      end
`else
      if (neg_q) {res_hi_o, res_lo_o} = -prod;
`endif
    end
  end

  always_comb begin
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
`ifdef ALU_CTRL_DIV_EN
    div_d    = div_q;
`endif
    if (start_i) begin
      acc_hi_d = '0;
      neg_d    = sgn_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
      rneg_d   = sgn_i & a_i[WIDTH-1];
      acc_lo_d = b_mag;
      opnd_d   = a_mag;
`ifdef ALU_CTRL_DIV_EN
      div_d    = div_i;
      if (div_i) begin
        acc_lo_d = a_mag;
        opnd_d   = b_mag;
      end
`endif
    end else if (step_i) begin
      acc_hi_d = nxt_hi;
      acc_lo_d = nxt_lo;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
`ifdef ALU_CTRL_DIV_EN
      div_q    <= 1'b0;
`endif
    end else begin
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
`ifdef ALU_CTRL_DIV_EN
      div_q    <= div_d;
`endif
    end
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control decode plus HI/LO owner and multi-cycle MULT/DIV sequencer with interlock.
// DIV/DIVU are decoded and executed only when ALU_CTRL_DIV_EN is defined.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int ALUOP_W = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic [ALUOP_W-1:0] ALUOp_i,
  input  logic [5:0]         funct_i,
  input  logic [WIDTH-1:0]   src1_i,
  input  logic [WIDTH-1:0]   src2_i,
  output logic [3:0]         ALUCtrl_o,
  output logic               illegal_o,
  output logic               stall_o,
  output logic               md_done_o,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o,
  output logic [1:0]         state_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  md_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, res_hi, res_lo;
  logic             is_mul, is_div, is_mf, is_md, sgn, issue, div0;
  logic             start, step, last;

  always_comb begin
    ALUCtrl_o = CTRL_ILL;
    is_mul    = 1'b0;
    is_div    = 1'b0;
    is_mf     = 1'b0;
    sgn       = 1'b0;
    case (ALUOp_i)
      ALUOP_W'(ALUOP_MEM):  ALUCtrl_o = CTRL_ADD;
      ALUOP_W'(ALUOP_BEQ):  ALUCtrl_o = CTRL_SUB;
      ALUOP_W'(ALUOP_SLTI): ALUCtrl_o = CTRL_SLT;
      ALUOP_W'(ALUOP_ORI):  ALUCtrl_o = CTRL_OR;
      ALUOP_W'(ALUOP_ANDI): ALUCtrl_o = CTRL_AND;
      ALUOP_W'(ALUOP_RTYPE): begin
        case (funct_i)
          FN_ADD:   ALUCtrl_o = CTRL_ADD;
          FN_SUB:   ALUCtrl_o = CTRL_SUB;
          FN_AND:   ALUCtrl_o = CTRL_AND;
          FN_OR:    ALUCtrl_o = CTRL_OR;
          FN_NOR:   ALUCtrl_o = CTRL_NOR;
          FN_SLT:   ALUCtrl_o = CTRL_SLT;
          FN_MFHI:  begin ALUCtrl_o = CTRL_MFHI; is_mf = 1'b1; end
          FN_MFLO:  begin ALUCtrl_o = CTRL_MFLO; is_mf = 1'b1; end
          FN_MULT:  begin ALUCtrl_o = CTRL_MD; is_mul = 1'b1; sgn = 1'b1; end
          FN_MULTU: begin ALUCtrl_o = CTRL_MD; is_mul = 1'b1; end
`ifdef ALU_CTRL_DIV_EN
          FN_DIV:   begin ALUCtrl_o = CTRL_MD; is_div = 1'b1; sgn = 1'b1; end
          FN_DIVU:  begin ALUCtrl_o = CTRL_MD; is_div = 1'b1; end
`endif
          default:  ALUCtrl_o = CTRL_ILL;
        endcase
      end
      default: ALUCtrl_o = CTRL_ILL;
    endcase
  end

  // Only md ops and HI/LO reads wait for a running sequence; everything else flows past it.
  assign is_md     = is_mul | is_div;
  assign illegal_o = valid_i & (ALUCtrl_o == CTRL_ILL);
  assign stall_o   = valid_i & (state_q == ST_BUSY) & (is_mf | is_md);
  assign issue     = valid_i & is_md & (state_q != ST_BUSY);
  assign div0      = is_div & (src2_i == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    start   = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state_q)
      ST_BUSY: begin
        step = 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          last    = 1'b1;
          hi_d    = res_hi;
          lo_d    = res_lo;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (issue) begin
          cnt_d = '0;
          if (div0) begin
            hi_d    = src1_i;
            lo_d    = '1;
            state_d = ST_DONE;
          end else begin
            start   = 1'b1;
            state_d = ST_BUSY;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign md_done_o = (state_q == ST_DONE);
  assign hi_o      = hi_q;
  assign lo_o      = lo_q;
  assign state_o   = state_q;

  alu_md_iter #(.WIDTH(WIDTH)) u_md (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
`ifdef ALU_CTRL_DIV_EN
    .div_i    (is_div),
`endif
    .start_i  (start),
    .step_i   (step),
    .last_i   (last),
    .sgn_i    (sgn),
    .a_i      (src1_i),
    .b_i      (src2_i),
    .res_hi_o (res_hi),
    .res_lo_o (res_lo)
  );

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Bench for alu_ctrl_seq: directed decode/interlock vectors, and a scoreboard that
// checks HI/LO and the completion cycle on every md_done_o pulse.
module tb_alu_ctrl_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid = 1'b0;
  logic [2:0]   aluop = 3'b000;
  logic [5:0]   funct = 6'h00;
  logic [W-1:0] src1 = '0;
  logic [W-1:0] src2 = '0;
  logic [3:0]   alu_ctrl;
  logic         illegal, stall, md_done;
  logic [W-1:0] hi, lo;
  logic [1:0]   state;

  int cyc = 0;
  int pass_cnt = 0;
  int total_cnt = 0;

  logic [2*W-1:0] exp_q[$];
  int             exp_cyc_q[$];
  logic [2*W-1:0] mon_e;
  int             mon_c;

  alu_ctrl_seq #(.WIDTH(W), .ALUOP_W(3)) dut (
    .clk_i     (clk),
    .rst_i     (rst_n),
    .valid_i   (valid),
    .ALUOp_i   (aluop),
    .funct_i   (funct),
    .src1_i    (src1),
    .src2_i    (src2),
    .ALUCtrl_o (alu_ctrl),
    .illegal_o (illegal),
    .stall_o   (stall),
    .md_done_o (md_done),
    .hi_o      (hi),
    .lo_o      (lo),
    .state_o   (state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] fn,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    valid = v; aluop = op; funct = fn; src1 = a; src2 = b;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 3'b000, 6'h00, '0, '0);
      tick();
    end
  endtask

  // Issue an R-type md op this cycle and register its expected result and completion cycle.
  task automatic issue_md(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] e_hi, input logic [W-1:0] e_lo, input int lat);
    drive(1'b1, 3'b010, fn, a, b);
    exp_q.push_back({e_hi, e_lo});
    exp_cyc_q.push_back(cyc + lat);
  endtask

  task automatic decode_vec(input string name, input logic v, input logic [2:0] op,
                            input logic [5:0] fn, input logic [3:0] e_ctrl, input logic e_ill);
    drive(v, op, fn, '0, '0);
    @(negedge clk);
    check({name, "_ctrl"}, 64'(alu_ctrl), 64'(e_ctrl));
    check({name, "_illegal"}, 64'(illegal), 64'(e_ill));
    tick();
  endtask

  // Monitor: every completion pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (md_done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(1), 64'(0));
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        check("md_hi", 64'(hi), 64'(mon_e[2*W-1:W]));
        check("md_lo", 64'(lo), 64'(mon_e[W-1:0]));
        check("md_done_cycle", 64'(cyc), 64'(mon_c));
      end
    end
  end

  initial begin
    int c0;
    // Reset
    rst_n = 1'b0;
    tick(); tick();
    @(negedge clk);
    check("rst_state", 64'(state), 64'(0));
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    check("rst_done", 64'(md_done), 64'(0));
    check("rst_stall", 64'(stall), 64'(0));
    tick();
    rst_n = 1'b1;
    tick();

    // Decode sweep
    decode_vec("dec_mem",   1'b1, 3'b000, 6'h00, 4'b0010, 1'b0);
    decode_vec("dec_slt",   1'b1, 3'b010, 6'h2A, 4'b0111, 1'b0);
    decode_vec("dec_nor",   1'b1, 3'b010, 6'h27, 4'b1100, 1'b0);
    decode_vec("dec_bad",   1'b1, 3'b010, 6'h3F, 4'b1111, 1'b1);
    decode_vec("dec_ori",   1'b1, 3'b100, 6'h00, 4'b0001, 1'b0);
    decode_vec("dec_op7",   1'b1, 3'b111, 6'h00, 4'b1111, 1'b1);
    decode_vec("dec_novld", 1'b0, 3'b010, 6'h3F, 4'b1111, 1'b0);
    decode_vec("dec_mfhi",  1'b1, 3'b010, 6'h10, 4'b1000, 1'b0);

    // MULTU 0xFFFFFFFF x 2
    issue_md(6'h19, 32'hFFFF_FFFF, 32'h2, 32'h1, 32'hFFFF_FFFE, W + 1);
    tick();
    idle_n(W + 4);

    // MULT -3 x 5
    issue_md(6'h18, 32'hFFFF_FFFD, 32'h5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, W + 1);
    tick();
    idle_n(W + 4);

`ifdef ALU_CTRL_DIV_EN
    // DIV -7 / 2
    issue_md(6'h1A, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, W + 1);
    tick();
    idle_n(W + 4);
    // DIVU 9 / 0
    issue_md(6'h1B, 32'h9, 32'h0, 32'h9, 32'hFFFF_FFFF, 1);
    tick();
    idle_n(4);
`else
    decode_vec("div_off",  1'b1, 3'b010, 6'h1A, 4'b1111, 1'b1);
    decode_vec("divu_off", 1'b1, 3'b010, 6'h1B, 4'b1111, 1'b1);
    idle_n(W + 4);
    @(negedge clk);
    check("div_off_hi", 64'(hi), 64'(32'hFFFF_FFFF));
    check("div_off_lo", 64'(lo), 64'(32'hFFFF_FFF1));
    tick();
`endif

    // Interlock: MULT 7 x 6, ADD in cycle 3, MFLO held from cycle 5
    c0 = cyc;
    issue_md(6'h18, 32'h7, 32'h6, 32'h0, 32'd42, W + 1);
    @(negedge clk);
    check("stall_issue", 64'(stall), 64'(0));
    tick();
    for (int k = 1; k <= W + 1; k++) begin
      if (k == 3) drive(1'b1, 3'b010, 6'h20, '0, '0);
      else if (k >= 5) drive(1'b1, 3'b010, 6'h12, '0, '0);
      else drive(1'b0, 3'b000, 6'h00, '0, '0);
      @(negedge clk);
      if (k == 3) check("stall_add", 64'(stall), 64'(0));
      else if (k >= 5 && k <= W) check("stall_mflo", 64'(stall), 64'(1));
      else if (k == W + 1) begin
        check("stall_mflo_done", 64'(stall), 64'(0));
        check("mflo_value", 64'(lo), 64'(42));
        check("mflo_cycle", 64'(cyc - c0), 64'(W + 1));
      end
      tick();
    end
    idle_n(3);

    // Back-to-back: second MULTU issued in the DONE cycle of the first
    issue_md(6'h19, 32'h3, 32'h4, 32'h0, 32'd12, W + 1);
    tick();
    for (int k = 1; k <= W + 2; k++) begin
      if (k == W + 1) issue_md(6'h19, 32'h5, 32'h6, 32'h0, 32'd30, W + 1);
      else drive(1'b0, 3'b000, 6'h00, '0, '0);
      @(negedge clk);
      if (k == W + 1) check("b2b_stall", 64'(stall), 64'(0));
      if (k == W + 2) check("b2b_busy", 64'(state), 64'(1));
      tick();
    end
    idle_n(W + 4);

    // Reset in cycle 10 of a running op: no pulse, state and HI/LO cleared
`ifdef ALU_CTRL_DIV_EN
    drive(1'b1, 3'b010, 6'h1B, 32'd100, 32'd7);
`else
    drive(1'b1, 3'b010, 6'h19, 32'd100, 32'd7);
`endif
    tick();
    for (int k = 1; k <= 10; k++) begin
      drive(1'b0, 3'b000, 6'h00, '0, '0);
      if (k == 10) rst_n = 1'b0;
      @(negedge clk);
      if (k == 10) check("pre_rst_busy", 64'(state), 64'(1));
      tick();
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_state", 64'(state), 64'(0));
    check("mid_rst_hi", 64'(hi), 64'(0));
    check("mid_rst_lo", 64'(lo), 64'(0));
    tick();
    idle_n(W + 4);

    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
